mult_scheduler: RTL
===================

Name: mult_scheduler

Overview:
- Shares one shift-add multiplier datapath between two requesters.
- Performs round-robin arbitration, captures the winner's operands and sequences the add/shift cycles itself.
- Returns the product with a one-cycle completion pulse to the owning requester.
- Sits between client blocks and the multiplier: it owns the accumulator/multiplier registers and the add/shift control that a standalone sequencer would otherwise drive.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
- clock  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  2  request per requester; bit i = requester i.
- a_in0  input  WIDTH  multiplicand, requester 0.
- b_in0  input  WIDTH  multiplier, requester 0.
- a_in1  input  WIDTH  multiplicand, requester 1.
- b_in1  input  WIDTH  multiplier, requester 1.
- gnt  output  2  one-hot grant pulse, one cycle, operands captured that cycle.
- done  output  2  one-hot completion pulse, one cycle, to the owning requester.
- product  output  2*WIDTH  last completed product; held until the next completion.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; gnt=0, done=0, busy=0, product=0; acc=0, mreg=0, mcand=0, carry=0; count=0; owner=0; last_grant=1, so requester 0 wins the first tie. Reset mid-operation abandons the job: no done pulse, product cleared.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select a winner: a single requester wins directly; if both request, the winner is the one != last_grant.
  - gnt[winner]=1 combinationally in this cycle.
  - On the clock edge: mcand<=a_inW, mreg<=b_inW, acc<=0, carry<=0, count<=WIDTH, owner<=W, last_grant<=W, next state ADD.
- ADD:
  - If mreg[0]=1: {carry,acc} <= acc + mcand, with the sum computed at WIDTH+1 bits; else acc and carry are unchanged.
  - count <= count-1; next state SHIFT.
- SHIFT:
  - {carry,acc,mreg} <= {1'b0,carry,acc,mreg} >> 1, i.e. a logical right shift of the 2*WIDTH+1 bit concatenation; carry becomes 0.
  - If count != 0, next state ADD; else DONE.
- DONE:
  - done[owner]=1 for this cycle only.
  - product <= {acc,mreg} on the edge leaving DONE; next state IDLE.
- Latency: the first done pulse is 2*WIDTH+1 cycles after the gnt cycle. product is valid from the cycle after done and stays stable until the next completion. Minimum spacing between successive grants is 2*WIDTH+2 cycles.
- Request handshake:
  - A requester holds req and its operands stable until it sees its gnt bit.
  - After gnt, req may drop. req still high in the IDLE cycle after DONE counts as a new request.
  - req changes while busy are ignored, as are operand changes after gnt.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- Arithmetic: unsigned; no overflow is possible because the carry bit covers WIDTH+1 bits. count width is $clog2(WIDTH+1).
- Invariants: gnt and done are never both nonzero; at most one bit of each is set; busy=0 exactly when state=IDLE.
- Default assignments in the combinational block: gnt=0, done=0, next_state=state. The case statement covers all four states.

Test Plan:
- Basic multiply: WIDTH=4; req=01 with a_in0=13, b_in0=11 -> gnt=01 for one cycle; done=01 exactly 9 cycles later; product=143 (0x8F) the following cycle; busy high from the cycle after gnt through DONE.
- Tie and fairness: req=11 held continuously, a_in0=15, b_in0=15, a_in1=3, b_in1=5 -> grant order 0,1,0,1; products alternate 225, 15, 225, 15; each done goes to the granted requester.
- Zero and edge operands: 0*9 gives product=0; 9*0 gives product=0; 1*15 gives product=15. Latency is 9 cycles regardless of operand bits.
- Request masking while busy: requester 0 granted, then req[1] asserted and deasserted mid-job -> no gnt[1] issued, job 0 completes normally, state returns to IDLE with gnt=00.
- Reset mid-operation: assert rst 4 cycles after gnt -> immediately state=IDLE, busy=0, product=0, no done pulse. After release with req=11, requester 0 is granted first.
- Back-to-back single requester: req[0] held high with changing operands 7*6, then 12*12 -> second gnt one cycle after the first done; products 42 then 144.

Source files
------------

// File: rtl/mult_scheduler.sv
// rtl/mult_scheduler.sv - round-robin scheduler owning a shared shift-add multiplier
module mult_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [WIDTH-1:0]   a_in0,
    input  logic [WIDTH-1:0]   b_in0,
    input  logic [WIDTH-1:0]   a_in1,
    input  logic [WIDTH-1:0]   b_in1,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] acc, mreg, mcand;
    logic             carry;
    logic [CW-1:0]    count;
    logic             owner, last_grant, winner;
    logic [WIDTH:0]   sum;

    // On a tie the requester that did not win last time goes next.
    assign winner = (req == 2'b11) ? ~last_grant : req[1];
    assign sum    = {1'b0, acc} + {1'b0, mcand};
    assign busy   = (state != IDLE);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        gnt        = '0;
        done       = '0;
        case (state)
            IDLE: begin
                // No grant while reset is applied, so nothing is captured.
                if (req != 2'b00 && !rst) begin
                    gnt[winner] = 1'b1;
                    next_state  = ADD;
                end
            end
            ADD:   next_state = SHIFT;
            SHIFT: next_state = (count != '0) ? ADD : DONE;
            DONE: begin
                done[owner] = 1'b1;
                next_state  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            mreg       <= '0;
            mcand      <= '0;
            carry      <= 1'b0;
            count      <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            product    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        mcand      <= winner ? a_in1 : a_in0;
                        mreg       <= winner ? b_in1 : b_in0;
                        acc        <= '0;
                        carry      <= 1'b0;
                        count      <= CW'(WIDTH);
                        owner      <= winner;
                        last_grant <= winner;
                    end
                end
                ADD: begin
                    if (mreg[0]) {carry, acc} <= sum;
                    count <= count - 1'b1;
                end
                SHIFT: begin
                    // Logical right shift of {carry, acc, mreg}; carry refills acc's MSB.
                    carry <= 1'b0;
                    acc   <= {carry, acc[WIDTH-1:1]};
                    mreg  <= {acc[0], mreg[WIDTH-1:1]};
                end
                DONE: product <= {acc, mreg};
            endcase
        end
    end

endmodule
